// File: rtl/nibble_serializer.sv
// Purpose: buffers 4-bit words in a DEPTH-entry FIFO and sends each one as a frame: start bit, 4 data bits LSB first, stop bit.
// Latency: a word pushed into an empty FIFO is popped on the next edge, and ser_out falls after that edge; each bit lasts DIV cycles.
// Backpressure: in_ready drops while the FIFO is full. Define NIBBLE_SER_PARITY_EN to add an even-parity bit before the stop bit.
module nibble_serializer #(
    parameter int DEPTH = 4,
    parameter int DIV   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         ser_out,
    output logic                         busy,
    output logic                         frame_done,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef NIBBLE_SER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [3:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_nxt;
    logic [3:0]    r_shift;
    logic [3:0]    w_shift_nxt;
    logic          r_ser;
    logic          w_ser_nxt;
    logic          r_done;
    logic          w_done_nxt;

    logic          w_push;
    logic          w_pop;
    logic          w_bit_end;

    // Ready comes only from registered occupancy, and is forced low while in reset.
    assign in_ready  = !rst && (r_level != LW'(DEPTH));
    assign w_push    = in_valid && in_ready;
    assign w_bit_end = (r_cnt == CW'(DIV - 1));

    assign ser_out    = r_ser;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_done;
    assign level      = r_level;

    // FIFO storage: written on every accepted word, not reset (contents are invalid until pushed).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // Frame sequencer: next state, bit timing, line value and pop decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_bit_end ? '0 : r_cnt + CW'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_ser_nxt   = r_ser;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_state_nxt = START;
                    w_ser_nxt   = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_idx_nxt   = 2'd0;
                    w_ser_nxt   = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_idx == 2'd3) begin
`ifdef NIBBLE_SER_PARITY_EN
                        w_state_nxt = PARITY;
                        w_ser_nxt   = ^r_shift;
`else
                        w_state_nxt = STOP;
                        w_ser_nxt   = 1'b1;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                        w_ser_nxt = r_shift[r_idx + 2'd1];
                    end
                end
            end
`ifdef NIBBLE_SER_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_ser_nxt   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    w_done_nxt = 1'b1;
                    // Chain straight into the next frame when a word is waiting.
                    if (r_level != '0) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_state_nxt = START;
                        w_ser_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_ser_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ser_nxt   = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset aborts any frame and returns the line to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_ser   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_ser   <= w_ser_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: a DIV=4 and a DIV=1 instance share reset; only the selected one gets traffic.
// Reference: queue of buffered words plus a queue of expected line bits, one entry per cycle of every frame.
// Outputs are sampled on the falling clock edge; inputs are driven on the falling edge.
`timescale 1ns/1ps
module tb_nibble_serializer;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;
    localparam int LW    = $clog2(DEPTH + 1);
`ifdef NIBBLE_SER_PARITY_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    localparam int FL = NB * DIV;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [3:0]    in_data;
    logic          sel;
    logic          v4, v1;
    logic          r4, s4, b4, f4;
    logic          r1, s1, b1, f1;
    logic [LW-1:0] l4, l1;
    logic [LW+3:0] obs;

    int total = 0;
    int bad   = 0;

    assign v4  = in_valid && !sel;
    assign v1  = in_valid && sel;
    assign obs = sel ? {s1, b1, f1, l1, r1} : {s4, b4, f4, l4, r4};

    nibble_serializer #(.DEPTH(DEPTH), .DIV(DIV)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v4), .in_ready(r4),
        .ser_out(s4), .busy(b4), .frame_done(f4), .level(l4)
    );

    nibble_serializer #(.DEPTH(DEPTH), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v1), .in_ready(r1),
        .ser_out(s1), .busy(b1), .frame_done(f1), .level(l1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Line value for bit k of a frame carrying word w.
    function automatic bit fbit(input logic [3:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= 4) return w[k-1];
        if (NB == 7 && k == 5) return ^w;
        return 1'b1;
    endfunction

    // Reference model state.
    logic [3:0] m_fifo [$];
    bit         m_line [$];
    bit         m_last [$];
    bit         m_done;
    bit         m_push;
    bit         m_dummy;
    int         m_div;
    logic [3:0] m_w;

    initial begin
        m_done = 1'b0;
        forever begin
            @(posedge clk);
            m_div = sel ? 1 : DIV;
            if (rst) begin
                m_fifo.delete();
                m_line.delete();
                m_last.delete();
                m_done = 1'b0;
            end else begin
                m_push = in_valid && (m_fifo.size() != DEPTH);
                m_done = 1'b0;
                if (m_line.size() != 0) begin
                    m_done  = m_last.pop_front();
                    m_dummy = m_line.pop_front();
                end
                if (m_line.size() == 0 && m_fifo.size() != 0) begin
                    m_w = m_fifo.pop_front();
                    for (int k = 0; k < NB; k++) begin
                        for (int d = 0; d < m_div; d++) begin
                            m_line.push_back(fbit(m_w, k));
                            m_last.push_back(k == NB - 1 && d == m_div - 1);
                        end
                    end
                end
                if (m_push) m_fifo.push_back(in_data);
            end
        end
    end

    // Expected {ser_out, busy, frame_done, level, in_ready} from the model.
    function automatic logic [LW+3:0] exp_vec();
        logic s;
        s = (m_line.size() != 0) ? m_line[0] : 1'b1;
        return {s, (m_line.size() != 0), m_done, LW'(m_fifo.size()), (!rst && (m_fifo.size() != DEPTH))};
    endfunction

    task test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; sel = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (r4 !== 1'b0 || r1 !== 1'b0) begin bad++; $display("FAIL reset_ready got %b/%b want 0/0", r4, r1); end
        total++; if ({s4, b4, f4, l4} !== {3'b100, {LW{1'b0}}}) begin bad++; $display("FAIL reset_state4 got %b want %b", {s4, b4, f4, l4}, {3'b100, {LW{1'b0}}}); end
        total++; if ({s1, b1, f1, l1} !== {3'b100, {LW{1'b0}}}) begin bad++; $display("FAIL reset_state1 got %b want %b", {s1, b1, f1, l1}, {3'b100, {LW{1'b0}}}); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (r4 !== 1'b1) begin bad++; $display("FAIL reset_release_ready got %b want 1", r4); end
        total++; if (obs !== exp_vec()) begin bad++; $display("FAIL reset_release got %b want %b", obs, exp_vec()); end
    endtask

    task test_single();
        int busy_n, done_n, done_at;
        logic [3:0] w;
        w = 4'b1010; busy_n = 0; done_n = 0; done_at = -1;
        in_data = w; in_valid = 1'b1;
        for (int i = 1; i <= FL + 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL single_cyc%0d got %b want %b", i, obs, exp_vec()); end
            if (i >= 2 && i < 2 + FL) begin
                total++; if (s4 !== fbit(w, (i - 2) / DIV)) begin bad++; $display("FAIL single_bit cyc%0d got %b want %b", i, s4, fbit(w, (i - 2) / DIV)); end
            end
            if (b4) busy_n++;
            if (f4) begin done_n++; done_at = i; end
        end
        total++; if (busy_n != FL) begin bad++; $display("FAIL single_busy_len got %0d want %0d", busy_n, FL); end
        total++; if (done_n != 1 || done_at != 2 + FL) begin bad++; $display("FAIL single_done got %0d pulses at %0d want 1 at %0d", done_n, done_at, 2 + FL); end
        total++; if (l4 !== LW'(0)) begin bad++; $display("FAIL single_level got %0d want 0", l4); end
    endtask

    task test_back_to_back();
        int busy_n, done_n, first, last, prev_done, f, k;
        logic [3:0] words [3];
        words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3;
        busy_n = 0; done_n = 0; first = -1; last = -1; prev_done = -1;
        in_data = words[0]; in_valid = 1'b1;
        for (int i = 1; i <= 3 * FL + 8; i++) begin
            @(negedge clk);
            if (i == 1) in_data = words[1];
            else if (i == 2) in_data = words[2];
            else in_valid = 1'b0;
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL b2b_cyc%0d got %b want %b", i, obs, exp_vec()); end
            if (i >= 2 && i < 2 + 3 * FL) begin
                f = (i - 2) / FL;
                k = ((i - 2) % FL) / DIV;
                total++; if (s4 !== fbit(words[f], k)) begin bad++; $display("FAIL b2b_bit cyc%0d got %b want %b", i, s4, fbit(words[f], k)); end
            end
            if (b4) begin busy_n++; if (first < 0) first = i; last = i; end
            if (f4) begin
                if (prev_done >= 0) begin
                    total++; if (i - prev_done != FL) begin bad++; $display("FAIL b2b_done_gap got %0d want %0d", i - prev_done, FL); end
                end
                prev_done = i;
                done_n++;
            end
        end
        total++; if (done_n != 3) begin bad++; $display("FAIL b2b_done_count got %0d want 3", done_n); end
        total++; if (busy_n != 3 * FL || last - first + 1 != 3 * FL) begin bad++; $display("FAIL b2b_busy got %0d span %0d want %0d", busy_n, last - first + 1, 3 * FL); end
    endtask

    task test_fill();
        int sent, cyc, max_lvl;
        bit hs, saw_block, prev_rdy, cur_rdy;
        sent = 0; cyc = 0; max_lvl = 0; saw_block = 1'b0; prev_rdy = 1'b1;
        in_data = 4'h0; in_valid = 1'b1;
        hs = r4;
        while ((in_valid || b4 || l4 != LW'(0)) && cyc < 600) begin
            @(negedge clk);
            cyc++;
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL fill_cyc%0d got %b want %b", cyc, obs, exp_vec()); end
            cur_rdy = r4;
            if (!prev_rdy && cur_rdy) begin
                total++; if (l4 !== LW'(3)) begin bad++; $display("FAIL fill_ready_rise level got %0d want 3", l4); end
            end
            if (int'(l4) > max_lvl) max_lvl = int'(l4);
            if (!cur_rdy) saw_block = 1'b1;
            if (hs) begin
                in_data = in_data + 4'd1;
                sent++;
                if (sent == 10) in_valid = 1'b0;
            end
            hs = in_valid && cur_rdy;
            prev_rdy = cur_rdy;
        end
        total++; if (cyc >= 600) begin bad++; $display("FAIL fill_timeout got %0d cycles want <600", cyc); end
        total++; if (max_lvl != DEPTH || !saw_block) begin bad++; $display("FAIL fill_full got max %0d blocked %0b want %0d 1", max_lvl, saw_block, DEPTH); end
        total++; if (sent != 10) begin bad++; $display("FAIL fill_sent got %0d want 10", sent); end
    endtask

    task test_reset_mid();
        in_data = 4'h5; in_valid = 1'b1;
        for (int i = 1; i <= 2 + 3 * DIV; i++) begin
            @(negedge clk);
            if (i == 1) in_data = 4'h6;
            else if (i == 2) in_data = 4'h9;
            else in_valid = 1'b0;
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL rmid_cyc%0d got %b want %b", i, obs, exp_vec()); end
        end
        total++; if (l4 !== LW'(2) || b4 !== 1'b1) begin bad++; $display("FAIL rmid_queued got level %0d busy %b want 2 1", l4, b4); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({s4, b4, f4, l4, r4} !== {3'b100, {LW{1'b0}}, 1'b0}) begin bad++; $display("FAIL rmid_after got %b want %b", {s4, b4, f4, l4, r4}, {3'b100, {LW{1'b0}}, 1'b0}); end
        rst = 1'b0;
        for (int i = 1; i <= FL + 4; i++) begin
            @(negedge clk);
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL rmid_post%0d got %b want %b", i, obs, exp_vec()); end
            total++; if (f4 !== 1'b0 || s4 !== 1'b1) begin bad++; $display("FAIL rmid_quiet%0d got done %b ser %b want 0 1", i, f4, s4); end
        end
    endtask

    task test_div1();
        int busy_n, done_n;
        busy_n = 0; done_n = 0;
        sel = 1'b1; in_data = 4'hF; in_valid = 1'b1;
        for (int i = 1; i <= NB + 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL div1_cyc%0d got %b want %b", i, obs, exp_vec()); end
            if (i >= 2 && i < 2 + NB) begin
                total++; if (s1 !== fbit(4'hF, i - 2)) begin bad++; $display("FAIL div1_bit cyc%0d got %b want %b", i, s1, fbit(4'hF, i - 2)); end
            end
            if (b1) busy_n++;
            if (f1) done_n++;
        end
        total++; if (busy_n != NB || done_n != 1) begin bad++; $display("FAIL div1_frame got busy %0d done %0d want %0d 1", busy_n, done_n, NB); end
        sel = 1'b0;
    endtask

`ifdef NIBBLE_SER_PARITY_EN
    task test_parity();
        int busy_n, par_n;
        busy_n = 0; par_n = 0;
        in_data = 4'b0111; in_valid = 1'b1;
        for (int i = 1; i <= 7 * DIV + 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL par_cyc%0d got %b want %b", i, obs, exp_vec()); end
            if (i >= 2 + 5 * DIV && i < 2 + 6 * DIV && s4 === 1'b1) par_n++;
            if (b4) busy_n++;
        end
        total++; if (par_n != DIV) begin bad++; $display("FAIL par_bit got %0d high cycles want %0d", par_n, DIV); end
        total++; if (busy_n != 7 * DIV) begin bad++; $display("FAIL par_len got %0d want %0d", busy_n, 7 * DIV); end
    endtask
`endif

    task test_random();
        int cyc;
        for (int pass = 0; pass < 2; pass++) begin
            sel = (pass == 1);
            for (int i = 0; i < (pass == 0 ? 600 : 150); i++) begin
                @(negedge clk);
                total++; if (obs !== exp_vec()) begin bad++; $display("FAIL rand%0d_cyc%0d got %b want %b", pass, i, obs, exp_vec()); end
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = 4'($urandom);
            end
            in_valid = 1'b0;
            cyc = 0;
            while ((m_fifo.size() != 0 || m_line.size() != 0) && cyc < 2000) begin
                @(negedge clk);
                cyc++;
                total++; if (obs !== exp_vec()) begin bad++; $display("FAIL rand%0d_drain%0d got %b want %b", pass, cyc, obs, exp_vec()); end
            end
            @(negedge clk);
            total++; if (cyc >= 2000 || obs[LW+2] !== 1'b0) begin bad++; $display("FAIL rand%0d_idle got busy %b after %0d cycles want 0", pass, obs[LW+2], cyc); end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_reset_mid();
        test_div1();
`ifdef NIBBLE_SER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
